// File: rtl/gnn_pkg.sv
// rtl/gnn_pkg.sv - shared constants, state and record types for the GNN readout
package gnn_pkg;

    localparam int DW        = 21;
    localparam int NUM_NODES = 4;
    localparam int NW        = $clog2(NUM_NODES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2,
        ST_DONE    = 2'd3
    } rd_state_t;

    typedef struct packed {
        logic [NW-1:0]        node;
        logic                 cls;
        logic signed [DW-1:0] score;
        logic signed [DW:0]   margin;
    } res_rec_t;

endpackage

// File: rtl/gnn_readout_cmp.sv
// rtl/gnn_readout_cmp.sv - combinational two-class comparator (class, max score, margin)
module gnn_readout_cmp #(
    parameter int DW = gnn_pkg::DW
) (
    input  logic signed [DW-1:0] i_out0,
    input  logic signed [DW-1:0] i_out1,
    output logic                 o_class,
    output logic signed [DW-1:0] o_score,
    output logic signed [DW:0]   o_margin
);

    logic signed [DW:0] w_out0_ext;
    logic signed [DW:0] w_out1_ext;

    // One guard bit keeps out1 - out0 exact across the full input range.
    assign w_out0_ext = {i_out0[DW-1], i_out0};
    assign w_out1_ext = {i_out1[DW-1], i_out1};

    assign o_class  = (i_out1 > i_out0);
    assign o_score  = o_class ? i_out1 : i_out0;
    assign o_margin = w_out1_ext - w_out0_ext;

endmodule

// File: rtl/gnn_readout.sv
// rtl/gnn_readout.sv - collects layer-2 node results and emits per-node class records
module gnn_readout #(
    parameter int DW             = 21,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic signed [DW-1:0] out0_node0,
    input  logic signed [DW-1:0] out0_node1,
    input  logic signed [DW-1:0] out0_node2,
    input  logic signed [DW-1:0] out0_node3,
    input  logic signed [DW-1:0] out1_node0,
    input  logic signed [DW-1:0] out1_node1,
    input  logic signed [DW-1:0] out1_node2,
    input  logic signed [DW-1:0] out1_node3,
    input  logic                 out10_ready_node0,
    input  logic                 out10_ready_node1,
    input  logic                 out10_ready_node2,
    input  logic                 out10_ready_node3,
    input  logic                 out11_ready_node0,
    input  logic                 out11_ready_node1,
    input  logic                 out11_ready_node2,
    input  logic                 out11_ready_node3,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [1:0]           res_node,
    output logic                 res_class,
    output logic signed [DW-1:0] res_score,
    output logic signed [DW:0]   res_margin,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err
);

    import gnn_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    rd_state_t            r_state;
    rd_state_t            w_next;
    logic [NUM_NODES-1:0] r_cap0;
    logic [NUM_NODES-1:0] r_cap1;
    logic [NUM_NODES-1:0] w_cap0_nxt;
    logic [NUM_NODES-1:0] w_cap1_nxt;
    logic signed [DW-1:0] r_slot0     [NUM_NODES];
    logic signed [DW-1:0] r_slot1     [NUM_NODES];
    logic signed [DW-1:0] w_slot0_nxt [NUM_NODES];
    logic signed [DW-1:0] w_slot1_nxt [NUM_NODES];
    logic signed [DW-1:0] w_in0       [NUM_NODES];
    logic signed [DW-1:0] w_in1       [NUM_NODES];
    logic [NUM_NODES-1:0] w_rdy0;
    logic [NUM_NODES-1:0] w_rdy1;
    logic [TW-1:0]        r_tcnt;
    logic [NW-1:0]        r_node;
    logic [NW-1:0]        w_node_nxt;
    logic                 w_arm;
    logic                 w_all;
    logic                 w_tmo;
    logic                 w_hs;
    logic                 w_cls;
    logic signed [DW-1:0] w_score;
    logic signed [DW:0]   w_margin;
    res_rec_t             w_rec;
    res_rec_t             r_rec;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_terr;

    assign w_in0[0] = out0_node0;
    assign w_in0[1] = out0_node1;
    assign w_in0[2] = out0_node2;
    assign w_in0[3] = out0_node3;
    assign w_in1[0] = out1_node0;
    assign w_in1[1] = out1_node1;
    assign w_in1[2] = out1_node2;
    assign w_in1[3] = out1_node3;
    assign w_rdy0   = {out10_ready_node3, out10_ready_node2, out10_ready_node1, out10_ready_node0};
    assign w_rdy1   = {out11_ready_node3, out11_ready_node2, out11_ready_node1, out11_ready_node0};

    assign w_arm = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_hs  = r_valid && res_ready;
    assign w_tmo = (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

    // Slot capture: first ready wins, later ready/data changes are ignored.
    always_comb begin
        w_cap0_nxt = r_cap0;
        w_cap1_nxt = r_cap1;
        for (int n = 0; n < NUM_NODES; n++) begin
            w_slot0_nxt[n] = r_slot0[n];
            w_slot1_nxt[n] = r_slot1[n];
        end
        if (w_arm) begin
            w_cap0_nxt = '0;
            w_cap1_nxt = '0;
            for (int n = 0; n < NUM_NODES; n++) begin
                w_slot0_nxt[n] = '0;
                w_slot1_nxt[n] = '0;
            end
        end else if (r_state == ST_COLLECT) begin
            for (int n = 0; n < NUM_NODES; n++) begin
                if (!r_cap0[n] && w_rdy0[n]) begin
                    w_cap0_nxt[n]  = 1'b1;
                    w_slot0_nxt[n] = w_in0[n];
                end
                if (!r_cap1[n] && w_rdy1[n]) begin
                    w_cap1_nxt[n]  = 1'b1;
                    w_slot1_nxt[n] = w_in1[n];
                end
            end
        end
    end

    assign w_all = (&w_cap0_nxt) && (&w_cap1_nxt);

    always_comb begin
        w_next     = r_state;
        w_node_nxt = r_node;
        case (r_state)
            ST_IDLE: begin
                if (w_arm) begin
                    w_next     = ST_COLLECT;
                    w_node_nxt = '0;
                end
            end
            ST_COLLECT: begin
                if (w_all) begin
                    w_next     = ST_EMIT;
                    w_node_nxt = '0;
                end else if (w_tmo) begin
                    w_next = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (w_hs) begin
                    if (r_node == NW'(NUM_NODES - 1)) begin
                        w_next     = ST_DONE;
                        w_node_nxt = '0;
                    end else begin
                        w_node_nxt = r_node + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (w_arm) begin
                    w_next     = ST_COLLECT;
                    w_node_nxt = '0;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // The record is built from next-cycle slot/index values so res_valid rises
    // together with the state entering EMIT and the outputs stay registered.
    gnn_readout_cmp #(.DW(DW)) u_cmp (
        .i_out0   (w_slot0_nxt[w_node_nxt]),
        .i_out1   (w_slot1_nxt[w_node_nxt]),
        .o_class  (w_cls),
        .o_score  (w_score),
        .o_margin (w_margin)
    );

    always_comb begin
        w_rec        = '0;
        w_rec.node   = w_node_nxt;
        w_rec.cls    = w_cls;
        w_rec.score  = w_score;
        w_rec.margin = w_margin;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cap0  <= '0;
            r_cap1  <= '0;
            for (int n = 0; n < NUM_NODES; n++) begin
                r_slot0[n] <= '0;
                r_slot1[n] <= '0;
            end
            r_tcnt  <= '0;
            r_node  <= '0;
            r_rec   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_terr  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cap0  <= w_cap0_nxt;
            r_cap1  <= w_cap1_nxt;
            for (int n = 0; n < NUM_NODES; n++) begin
                r_slot0[n] <= w_slot0_nxt[n];
                r_slot1[n] <= w_slot1_nxt[n];
            end
            r_node <= w_node_nxt;
            if (w_arm) begin
                r_tcnt <= '0;
            end else if (r_state == ST_COLLECT) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
            r_rec   <= (w_next == ST_EMIT) ? w_rec : '0;
            r_valid <= (w_next == ST_EMIT);
            r_busy  <= (w_next == ST_COLLECT) || (w_next == ST_EMIT);
            r_done  <= (w_next == ST_DONE);
            if (w_arm) begin
                r_terr <= 1'b0;
            end else if ((r_state == ST_COLLECT) && !w_all && w_tmo) begin
                r_terr <= 1'b1;
            end
        end
    end

    assign res_valid   = r_valid;
    assign res_node    = r_rec.node;
    assign res_class   = r_rec.cls;
    assign res_score   = r_rec.score;
    assign res_margin  = r_rec.margin;
    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout_err = r_terr;

endmodule

// File: doc/gnn_readout.md
GNN_READOUT -- requirements
Module: gnn_readout

Interface
REQ-001 Parameter: DW, 21, signed width of each layer-2 output word.
REQ-002 Parameter: TIMEOUT_CYCLES, 64, maximum number of COLLECT cycles before the block aborts.
REQ-003 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous and active-low.
REQ-005 Port: start  in  1  single-cycle pulse that clears the result slots and arms collection.
REQ-006 Ports: out0_node0..out0_node3, out1_node0..out1_node3  in  DW (signed)  layer-2 results from the upstream GNN core.
REQ-007 Ports: out10_ready_node0..3, out11_ready_node0..3  in  1  per-result valid levels from the upstream core.
REQ-008 Port: res_valid  out  1  a result record is presented.
REQ-009 Port: res_ready  in  1  downstream accepts the record.
REQ-010 Port: res_node  out  2  node index of the record.
REQ-011 Port: res_class  out  1  1 when out1 > out0, else 0.
REQ-012 Port: res_score  out  DW (signed)  max(out0, out1).
REQ-013 Port: res_margin  out  DW+1 (signed)  out1 - out0, computed without overflow.
REQ-014 Ports: busy, done, timeout_err  out  1 each  status flags.

Function
REQ-015 The FSM has four states: IDLE, COLLECT, EMIT, DONE.
REQ-016 IDLE -> COLLECT on start; entry clears all 8 captured flags and the timeout counter.
REQ-017 In COLLECT, each slot latches its data on the first cycle its ready level is 1; after that the slot holds, and later ready or data changes are ignored.
REQ-018 COLLECT -> EMIT on the cycle after all 8 slots are captured, counting captures made in the same cycle; node index starts at 0.
REQ-019 The timeout counter increments on every COLLECT cycle.
REQ-020 If the timeout counter reaches TIMEOUT_CYCLES-1 without completion, the block sets timeout_err (sticky) and enters IDLE; if completion and timeout occur in the same cycle, completion wins.
REQ-021 In EMIT, res_valid = 1, and res_node/class/score/margin are derived from the captured slots of the current node index and held stable until res_ready.
REQ-022 An EMIT handshake (res_valid & res_ready) advances the node index; the handshake on node 3 moves the FSM to DONE.
REQ-023 Records are emitted strictly in node order 0,1,2,3, and res_valid never drops before its handshake.
REQ-024 A tie (out0 == out1) gives res_class = 0, res_score = out0, res_margin = 0.
REQ-025 busy = 1 in COLLECT and EMIT; done = 1 only in DONE.
REQ-026 start in DONE re-arms (-> COLLECT, done cleared); start in COLLECT or EMIT is ignored.
REQ-027 start clears timeout_err.
REQ-028 res_valid = 0 outside EMIT; res_* data outputs are 0 outside EMIT.
REQ-029 All outputs are registered; first res_valid is 1 cycle after the last capture.

Reset
REQ-030 rst_n low asynchronously forces IDLE and clears the captured flags, slots, node index, timeout counter, res_valid, res_*, busy, done and timeout_err to 0.
REQ-031 Reset asserted mid-COLLECT or mid-EMIT discards all partial results; no record is emitted after release until a new start.

Structure
REQ-032 Package gnn_pkg holds DW, NUM_NODES = 4, the readout state enum, and the result-record struct (node, class, score, margin).
REQ-033 One sub-module, gnn_readout_cmp, is combinational: it takes two DW signed inputs and produces class, score and margin; it is instantiated once and fed by a node-index mux.

Verification
REQ-034 All eight inputs = 486000 with all readys high one cycle after start -> 4 records: node 0..3, class 0, score 486000, margin 0; then done = 1.
REQ-035 node0 out0 = -6358, out1 = -4188 -> class 1, score -4188, margin 2170; node2 out0 = -6287, out1 = -4587 -> class 1, margin 1700.
REQ-036 Ready levels staggered across 10 cycles, with data changed after its ready asserts -> records carry the first-captured values; res_valid rises 1 cycle after the last ready.
REQ-037 res_ready held low 5 cycles per record -> res_valid and the data stay stable, no record is skipped or repeated, and done follows the node-3 handshake.
REQ-038 out11_ready_node3 never asserts -> timeout_err = 1 after 64 COLLECT cycles, FSM returns to IDLE, no res_valid; a new start clears timeout_err.
REQ-039 rst_n pulsed low during the node-1 record -> all outputs 0 immediately; no records after release until start.
